// File: rtl/rlwe_imem_seq.sv
// -----------------------------------------------------------------------------
// rlwe_imem_seq
//
// This block sequences the instruction memory of the RLWE core. The SRAM is
// outside the block, but this block drives all of its ports.
//
//   Load phase: words are popped from the host instruction FIFO and written to
//   the 1R1W instruction SRAM, one word per cycle.
//   Run phase:  on a start request, the loaded program is read back from the
//   SRAM. It is sent to the datapath over a valid/ready issue port.
//
// Optional feature (compile-time macro RLWE_SEQ_LOOP_EN):
//   When the macro is defined and loop = 1 at the end of the program, RUN
//   restarts at address 0. There is no DONE pulse in that case. When the macro
//   is undefined, the loop port is ignored.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   empty, dequeue_en, fifo_data host FIFO: status, pop, head word
//   imem_we/waddr/wdata          SRAM write port
//   imem_re/raddr/rdata          SRAM read port (rdata valid the cycle after re)
//   start, abort, loop           control: run request, sync abort, loop enable
//   instr_valid/ready/data       issue interface to the datapath
//   busy, done, overflow         status: LOAD/RUN, end-of-program pulse,
//                                sticky load overflow
// -----------------------------------------------------------------------------
module rlwe_imem_seq #(
  parameter int unsigned  WIDTH      = 64,
  parameter int unsigned  MAX_SIZE   = 1024,
  localparam int unsigned ADDR_WIDTH = $clog2(MAX_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Host instruction FIFO
  input  logic                  empty,
  output logic                  dequeue_en,
  input  logic [WIDTH-1:0]      fifo_data,
  // Instruction SRAM
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [WIDTH-1:0]      imem_wdata,
  output logic                  imem_re,
  output logic [ADDR_WIDTH-1:0] imem_raddr,
  input  logic [WIDTH-1:0]      imem_rdata,
  // Control
  input  logic                  start,
  input  logic                  abort,
  input  logic                  loop,
  // Issue interface
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [WIDTH-1:0]      instr_data,
  // Status
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // One extra pointer bit so that a completely full memory (MAX_SIZE) can be
  // represented.
  localparam int unsigned    PtrW   = ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0] MaxPtr = PtrW'(MAX_SIZE);
  localparam logic [PtrW-1:0] OnePtr = PtrW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] prog_len_q, prog_len_d;
  logic [PtrW-1:0] pop_cnt_q, pop_cnt_d;     // words handed to the datapath this pass
  logic            start_pend_q, start_pend_d;
  logic            overflow_q, overflow_d;

  // Output FIFO (2 entries) and the read in flight toward it
  logic [WIDTH-1:0] ofifo_q [2];
  logic [1:0]       occ_q, occ_d;
  logic             ofifo_wr_q, ofifo_wr_d;
  logic             ofifo_rd_q, ofifo_rd_d;
  logic             in_flight_q, in_flight_d;

  // ---------------------------------------------------------------------------
  // Loop option
  // ---------------------------------------------------------------------------
  logic loop_en;
`ifdef RLWE_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  logic       start_req;
  logic       load_wr;
  logic       pop;
  logic       push;
  logic       last_pop;
  logic       can_issue;
  logic [2:0] pipe_fill;

  // A start request in the current cycle counts right away. This lets an
  // empty-program start finish DONE in a single cycle.
  assign start_req = start_pend_q | start;

  // The write is suppressed during an abort cycle. Otherwise a popped word
  // would be lost when the pointers are cleared.
  assign load_wr = (state_q == StLoad) && !empty && (wr_ptr_q < MaxPtr) && !abort;

  assign pop  = instr_valid && instr_ready;
  assign push = in_flight_q;

  assign last_pop = pop && (pop_cnt_q == (prog_len_q - OnePtr));

  // Slots already committed after this cycle's pop: words buffered plus the
  // read in flight. A new read is allowed only while this stays below two, so
  // the output FIFO can never overflow.
  assign pipe_fill = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};

  assign can_issue = (state_q == StRun) && !abort && (rd_ptr_q < prog_len_q) &&
                     (pipe_fill < 3'd2);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    prog_len_d   = prog_len_q;
    pop_cnt_d    = pop_cnt_q;
    overflow_d   = overflow_q;
    // start is latched in every state except RUN
    start_pend_d = start_pend_q | (start && (state_q != StRun));

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StLoad;
        end else if (start_req) begin
          state_d      = (prog_len_q == '0) ? StDone : StRun;
          start_pend_d = 1'b0;
        end
      end

      StLoad: begin
        if (load_wr) begin
          wr_ptr_d   = wr_ptr_q + OnePtr;
          prog_len_d = wr_ptr_q + OnePtr;
        end
        // A full memory leaves any remaining words in the FIFO.
        if (!empty && (wr_ptr_q == MaxPtr)) begin
          overflow_d = 1'b1;
        end
        // The drain finishes before a start takes effect.
        if (empty && start_req) begin
          state_d      = (prog_len_q == '0) ? StDone : StRun;
          start_pend_d = 1'b0;
        end
      end

      StRun: begin
        if (can_issue) begin
          rd_ptr_d = rd_ptr_q + OnePtr;
        end
        if (pop) begin
          pop_cnt_d = pop_cnt_q + OnePtr;
        end
        if (last_pop) begin
          if (loop_en) begin
            // All reads have already retired (rd_ptr == prog_len), so
            // restarting at 0 cannot collide with an issue in this cycle.
            rd_ptr_d  = '0;
            pop_cnt_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d    = StIdle;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        prog_len_d = '0;
        pop_cnt_d  = '0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // abort wins over start, DONE and loop
    if (abort) begin
      state_d      = StIdle;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      prog_len_d   = '0;
      pop_cnt_d    = '0;
      start_pend_d = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  // Output FIFO bookkeeping
  always_comb begin
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    ofifo_wr_d  = ofifo_wr_q ^ push;
    ofifo_rd_d  = ofifo_rd_q ^ pop;
    in_flight_d = can_issue;
    if (abort) begin
      occ_d       = 2'd0;
      ofifo_wr_d  = 1'b0;
      ofifo_rd_d  = 1'b0;
      in_flight_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      prog_len_q   <= '0;
      pop_cnt_q    <= '0;
      start_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      occ_q        <= 2'd0;
      ofifo_wr_q   <= 1'b0;
      ofifo_rd_q   <= 1'b0;
      in_flight_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      prog_len_q   <= prog_len_d;
      pop_cnt_q    <= pop_cnt_d;
      start_pend_q <= start_pend_d;
      overflow_q   <= overflow_d;
      occ_q        <= occ_d;
      ofifo_wr_q   <= ofifo_wr_d;
      ofifo_rd_q   <= ofifo_rd_d;
      in_flight_q  <= in_flight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofifo_q[0] <= '0;
      ofifo_q[1] <= '0;
    end else if (push) begin
      ofifo_q[ofifo_wr_q] <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dequeue_en  = load_wr;
  assign imem_we     = load_wr;
  assign imem_waddr  = wr_ptr_q[ADDR_WIDTH-1:0];
  assign imem_wdata  = fifo_data;
  assign imem_re     = can_issue;
  assign imem_raddr  = rd_ptr_q[ADDR_WIDTH-1:0];

  assign instr_valid = (occ_q != 2'd0);
  // Driven to zero when no word is valid, so that stale data never appears
  // on the issue bus.
  assign instr_data  = instr_valid ? ofifo_q[ofifo_rd_q] : '0;

  assign busy        = (state_q == StLoad) || (state_q == StRun);
  assign done        = (state_q == StDone);
  assign overflow    = overflow_q;

endmodule
